// File: rtl/spi_byte_rx.sv
// SPI-style serial receiver: synchronizes sck/cs_n/sdi into clk, assembles
// WIDTH-bit words and strobes each completed word out on en_out.
module spi_byte_rx #(
    parameter int WIDTH       = 8,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             cs_n,
    input  logic             sdi,
    output logic [WIDTH-1:0] d_out,
    output logic             en_out,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_s;
    logic                   cs_s;
    logic                   sdi_s;
    logic                   sck_prev;
    logic                   rise;

    logic [0:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_next;

    // cs_n chain resets high so a reset never looks like a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sck_prev <= sck_s;
        end
    end

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_prev;

    always_comb begin
        shift_next = shreg;
        if (MSB_FIRST != 0) begin
            shift_next = {shreg[WIDTH-2:0], sdi_s};
        end else begin
            shift_next = {sdi_s, shreg[WIDTH-1:1]};
        end
    end

    // en_out is a bare strobe (no ready): the downstream enable register
    // captures d_out in exactly the cycle en_out is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            d_out     <= '0;
            en_out    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            en_out    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    // Frame close wins over a coincident sck rise.
                    if (cs_s) begin
                        state <= IDLE;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (rise) begin
                        shreg <= shift_next;
                        if (bit_cnt == LAST) begin
                            d_out   <= shift_next;
                            en_out  <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: an MSB-first and an LSB-first instance share
// the same serial inputs; outputs are sampled on the falling clk edge.
module tb_spi_byte_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic       sdi;
    logic [7:0] d_out;
    logic       en_out;
    logic       frame_err;
    logic       busy;
    logic [7:0] d_out_lsb;
    logic       en_lsb;
    logic       ferr_lsb;
    logic       busy_lsb;

    always #5 clk = ~clk;

    spi_byte_rx #(.WIDTH(8), .MSB_FIRST(1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi),
        .d_out(d_out), .en_out(en_out), .frame_err(frame_err), .busy(busy)
    );

    spi_byte_rx #(.WIDTH(8), .MSB_FIRST(0), .SYNC_STAGES(2)) dut_lsb (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi),
        .d_out(d_out_lsb), .en_out(en_lsb), .frame_err(ferr_lsb), .busy(busy_lsb)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int en_cnt   = 0;
    int ferr_cnt = 0;
    int lsb_en   = 0;
    int lsb_ferr = 0;
    int dbl_cnt  = 0;
    int both_cnt = 0;
    int dchg_cnt = 0;
    logic       en_prev = 1'b0;
    logic [7:0] d_last  = 8'h00;

    // Observation of strobes and d_out stability on the MSB-first instance.
    always @(negedge clk) begin
        if (en_out === 1'b1) begin
            en_cnt++;
            got_q.push_back(d_out);
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (en_lsb === 1'b1) lsb_en++;
        if (ferr_lsb === 1'b1) lsb_ferr++;
        if (en_out === 1'b1 && en_prev === 1'b1) dbl_cnt++;
        if (en_out === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (rst === 1'b1 && en_out !== 1'b1 && d_out !== d_last) dchg_cnt++;
        en_prev = en_out;
        d_last  = d_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        wait_clk(4);
        sck = 1'b1;
        wait_clk(4);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic end_frame();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_d"}, d_out, 8'h00);
        chk({tag, "_en"}, en_out, 1'b0);
        chk({tag, "_ferr"}, frame_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_d_lsb"}, d_out_lsb, 8'h00);
        chk({tag, "_busy_lsb"}, busy_lsb, 1'b0);
    endtask

    initial begin
        int en0;
        int ferr0;
        logic [7:0] w;

        rst  = 1'b0;
        sck  = 1'b0;
        cs_n = 1'b1;
        sdi  = 1'b0;

        // Reset held while the serial pins toggle randomly.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sck = 1'($urandom_range(0, 1));
            sdi = 1'($urandom_range(0, 1));
            chk_reset_outputs("rst_hold");
        end
        sck = 1'b0;
        sdi = 1'b0;
        wait_clk(2);
        rst = 1'b1;
        wait_clk(8);
        chk_reset_outputs("rst_release");
        chk("rst_no_en", en_cnt, 0);

        // Single byte 0xA5 with exact strobe latency on the last bit.
        en0 = en_cnt; ferr0 = ferr_cnt;
        start_frame();
        chk("single_busy", busy, 1'b1);
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        sdi = w[0];
        wait_clk(4);
        sck = 1'b1;
        wait_clk(2);
        chk("lat_early_en", en_out, 1'b0);
        chk("lat_early_d", d_out, 8'h00);
        wait_clk(1);
        chk("lat_en", en_out, 1'b1);
        chk("lat_d", d_out, 8'hA5);
        exp_q.push_back(8'hA5);
        wait_clk(1);
        chk("lat_en_drop", en_out, 1'b0);
        wait_clk(1);
        sck = 1'b0;
        wait_clk(4);
        chk("single_busy_frame", busy, 1'b1);
        end_frame();
        chk("single_busy_after", busy, 1'b0);
        chk("single_en_cnt", en_cnt - en0, 1);
        chk("single_ferr_cnt", ferr_cnt - ferr0, 0);

        // Back-to-back words in one frame.
        en0 = en_cnt; ferr0 = ferr_cnt;
        start_frame();
        send_word(8'h3C);
        send_word(8'hC3);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        end_frame();
        chk("b2b_en_cnt", en_cnt - en0, 2);
        chk("b2b_first", got_q[en0], 8'h3C);
        chk("b2b_second", got_q[en0 + 1], 8'hC3);
        chk("b2b_hold", d_out, 8'hC3);
        chk("b2b_ferr_cnt", ferr_cnt - ferr0, 0);

        // Abort: full word then 5 stray bits.
        en0 = en_cnt; ferr0 = ferr_cnt;
        start_frame();
        send_word(8'hA5);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        end_frame();
        chk("abort_ferr_cnt", ferr_cnt - ferr0, 1);
        chk("abort_en_cnt", en_cnt - en0, 1);
        chk("abort_d_hold", d_out, 8'hA5);
        chk("abort_busy", busy, 1'b0);
        start_frame();
        send_word(8'h5A);
        exp_q.push_back(8'h5A);
        end_frame();
        chk("abort_next_d", d_out, 8'h5A);

        // Empty frame: no strobes at all.
        en0 = en_cnt; ferr0 = ferr_cnt;
        cs_n = 1'b0;
        wait_clk(6);
        chk("empty_busy", busy, 1'b1);
        cs_n = 1'b1;
        wait_clk(6);
        chk("empty_ferr", ferr_cnt - ferr0, 0);
        chk("empty_en", en_cnt - en0, 0);
        chk("empty_busy_after", busy, 1'b0);

        // cs_n rises together with the 8th sck rise: the rise is dropped.
        en0 = en_cnt; ferr0 = ferr_cnt;
        start_frame();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        sdi = 1'b1;
        wait_clk(4);
        sck  = 1'b1;
        cs_n = 1'b1;
        wait_clk(4);
        sck = 1'b0;
        wait_clk(6);
        chk("prio_ferr", ferr_cnt - ferr0, 1);
        chk("prio_en", en_cnt - en0, 0);
        chk("prio_d_hold", d_out, 8'h5A);
        chk("prio_busy", busy, 1'b0);

        // Reset in the middle of a word.
        en0 = en_cnt; ferr0 = ferr_cnt;
        start_frame();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rst = 1'b0;
        wait_clk(1);
        chk_reset_outputs("midrst");
        cs_n = 1'b1;
        sck  = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(6);
        chk_reset_outputs("midrst_release");
        chk("midrst_en", en_cnt - en0, 0);
        chk("midrst_ferr", ferr_cnt - ferr0, 0);

        // LSB-first instance alongside the MSB-first one.
        en0 = lsb_en;
        start_frame();
        send_word(8'hA5);
        exp_q.push_back(8'hA5);
        end_frame();
        chk("lsb_a5", d_out_lsb, 8'hA5);
        chk("msb_a5", d_out, 8'hA5);
        start_frame();
        send_word(8'hC8);
        exp_q.push_back(8'hC8);
        end_frame();
        chk("lsb_c8_bits", d_out_lsb, 8'h13);
        chk("msb_c8_bits", d_out, 8'hC8);
        chk("lsb_en_cnt", lsb_en - en0, 2);
        chk("lsb_ferr_total", lsb_ferr, 2);

        // Scoreboard and global invariants.
        chk("sb_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("sb_word%0d", i), got_q[i], exp_q[i]);
            else chk($sformatf("sb_missing%0d", i), 32'hFFFF_FFFF, exp_q[i]);
        end
        chk("no_double_en", dbl_cnt, 0);
        chk("no_en_with_ferr", both_cnt, 0);
        chk("d_out_only_on_en", dchg_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
